row_serializer: RTL and testbench
=================================

ROW_SERIALIZER -- requirements
Module: row_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each lane and of the output byte.
REQ-002 Parameter LANES, default 8: number of parallel input lanes per row word.
REQ-003 Parameter ROWS, default 8: number of rows per block, which drives the LASTo marker.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 STBi  input  1  upstream strobe; row word valid on DATi0..DATi7.
REQ-007 DATi0..DATi7  input  WIDTH each  row word, lane 0 to lane 7.
REQ-008 ACKi  output  1  row accepted this cycle; a transfer occurs when STBi=1 and ACKi=1.
REQ-009 STBo  output  1  output byte valid on DATo.
REQ-010 DATo  output  WIDTH  current output byte.
REQ-011 LASTo  output  1  DATo is the final byte (lane LANES-1, row ROWS-1) of a block.
REQ-012 ACKo  input  1  downstream accept; a transfer occurs when STBo=1 and ACKo=1.

Function
REQ-013 The block SHALL serialize each accepted row word into LANES consecutive output bytes in lane order 0..LANES-1.
REQ-014 The block SHALL use two states: EMPTY (no row held) and SHIFT (row held, lane counter valid).
REQ-015 In EMPTY, ACKi SHALL equal STBi. An input transfer SHALL capture all lanes into the hold register, set lane=0, and enter SHIFT on the next cycle.
REQ-016 In SHIFT, STBo SHALL be 1, DATo SHALL equal hold[lane], and LASTo SHALL be (lane==LANES-1 && row==ROWS-1).
REQ-017 In SHIFT with an output transfer and lane<LANES-1, lane SHALL increment by 1 and the held data SHALL be unchanged.
REQ-018 In SHIFT with an output transfer and lane==LANES-1, row SHALL increment modulo ROWS. The FSM SHALL go to EMPTY unless an input transfer happens in the same cycle.
REQ-019 ACKi in SHIFT SHALL be STBi && lane==LANES-1 && ACKo, a combinational path. A same-cycle input transfer SHALL reload hold, set lane=0 and stay in SHIFT, so back-to-back rows flow with zero bubble cycles.
REQ-020 In EMPTY, STBo=0 and LASTo=0; ACKo SHALL be ignored whenever STBo=0.
REQ-021 In SHIFT with ACKo=0, all state and outputs SHALL hold, and DATo SHALL stay stable until accepted.
REQ-022 STBi SHALL be ignored while ACKi=0, and the DATi lanes SHALL be sampled only on an input transfer.
REQ-023 Sustained throughput SHALL be one byte per cycle with ACKo held high. Latency from input transfer to first STBo SHALL be 1 cycle.
REQ-024 The row counter SHALL wrap from ROWS-1 to 0 on the final byte of a block, and LASTo SHALL assert exactly once per ROWS*LANES output bytes.

Reset
REQ-025 While RST=1 at a clock edge, the FSM SHALL enter EMPTY, lane=0, row=0, hold=0, and any partially emitted row SHALL be discarded.
REQ-026 Outputs after reset SHALL be STBo=0, DATo=0, LASTo=0, ACKi=STBi.
REQ-027 RST SHALL take priority over simultaneous input or output transfers in the same cycle.

Verification
REQ-028 Single row: lanes 0x10..0x17, STBi for 1 cycle, ACKo=1 -> DATo 0x10..0x17 on 8 consecutive cycles starting 1 cycle later, then STBo=0, LASTo=0 throughout.
REQ-029 Full block: 8 rows with row r = {8r..8r+7}, STBi held high, ACKo=1 -> 64 contiguous bytes 0..63, no gaps, LASTo=1 only with byte 63, ACKi pulses at lane 7 cycles.
REQ-030 Backpressure: ACKo=0 for 5 cycles at lane 3 -> DATo held at the lane-3 value and STBo=1 throughout; resuming ACKo completes the remaining lanes 4..7 without loss or duplication.
REQ-031 Simultaneous load/drain: next row presented while lane 7 is accepted -> ACKi=1 that cycle, next cycle DATo=new lane 0, no EMPTY cycle.
REQ-032 Reset mid-operation: RST at row 2 lane 4 -> next cycle STBo=0, DATo=0. Then a fresh block -> LASTo on its 64th byte, confirming row=0 after reset.
REQ-033 Spurious ACKo: ACKo=1 while EMPTY for 10 cycles -> no state change; the first subsequent row starts at lane 0.

Source files
------------

// File: rtl/row_serializer.sv
// Row-to-byte serializer: accepts a LANES-wide row word and emits it one lane per cycle,
// flagging the last byte of every ROWS-row block. The next row may load as the last lane drains.
module row_serializer #(
    parameter int WIDTH = 8,
    parameter int LANES = 8,
    parameter int ROWS  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STBi,
    input  logic [WIDTH-1:0] DATi0,
    input  logic [WIDTH-1:0] DATi1,
    input  logic [WIDTH-1:0] DATi2,
    input  logic [WIDTH-1:0] DATi3,
    input  logic [WIDTH-1:0] DATi4,
    input  logic [WIDTH-1:0] DATi5,
    input  logic [WIDTH-1:0] DATi6,
    input  logic [WIDTH-1:0] DATi7,
    output logic             ACKi,
    output logic             STBo,
    output logic [WIDTH-1:0] DATo,
    output logic             LASTo,
    input  logic             ACKo
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    typedef enum logic {
        EMPTY,
        SHIFT
    } state_t;

    state_t           state;
    logic [LW-1:0]    lane;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] hold [LANES];
    logic [WIDTH-1:0] dat_in [8];

    logic last_lane;
    logic in_xfer;
    logic out_xfer;

    assign dat_in[0] = DATi0;
    assign dat_in[1] = DATi1;
    assign dat_in[2] = DATi2;
    assign dat_in[3] = DATi3;
    assign dat_in[4] = DATi4;
    assign dat_in[5] = DATi5;
    assign dat_in[6] = DATi6;
    assign dat_in[7] = DATi7;

    assign last_lane = (lane == LANE_LAST);

    // In SHIFT a new row is only taken while the final lane is leaving, giving zero-bubble reloads.
    assign ACKi     = (state == EMPTY) ? STBi : (STBi && last_lane && ACKo);
    assign STBo     = (state == SHIFT);
    assign DATo     = STBo ? hold[lane] : '0;
    assign LASTo    = STBo && last_lane && (row == ROW_LAST);
    assign in_xfer  = STBi && ACKi;
    assign out_xfer = STBo && ACKo;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= EMPTY;
            lane  <= '0;
            row   <= '0;
            for (int i = 0; i < LANES; i++) begin
                hold[i] <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        for (int i = 0; i < LANES; i++) begin
                            hold[i] <= dat_in[i];
                        end
                        lane  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_xfer) begin
                        if (!last_lane) begin
                            lane <= lane + LW'(1);
                        end else begin
                            row  <= (row == ROW_LAST) ? '0 : row + RW'(1);
                            lane <= '0;
                            if (in_xfer) begin
                                for (int i = 0; i < LANES; i++) begin
                                    hold[i] <= dat_in[i];
                                end
                            end else begin
                                state <= EMPTY;
                            end
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_row_serializer.sv
// Directed bench for row_serializer: single row, full blocks, backpressure,
// zero-bubble reload, mid-row reset and ACKo while idle.
module tb_row_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       STBi;
    logic [7:0] DATi0, DATi1, DATi2, DATi3, DATi4, DATi5, DATi6, DATi7;
    logic       ACKi;
    logic       STBo;
    logic [7:0] DATo;
    logic       LASTo;
    logic       ACKo;

    int vectors     = 0;
    int miscompares = 0;

    row_serializer #(.WIDTH(8), .LANES(8), .ROWS(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .STBi  (STBi),
        .DATi0 (DATi0),
        .DATi1 (DATi1),
        .DATi2 (DATi2),
        .DATi3 (DATi3),
        .DATi4 (DATi4),
        .DATi5 (DATi5),
        .DATi6 (DATi6),
        .DATi7 (DATi7),
        .ACKi  (ACKi),
        .STBo  (STBo),
        .DATo  (DATo),
        .LASTo (LASTo),
        .ACKo  (ACKo)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; lanes carry base, base+1, ... base+7.
    task automatic applyStimulus(input logic rst, input logic stb, input logic [7:0] base,
                                 input logic ackO);
        RST   = rst;
        STBi  = stb;
        DATi0 = base;
        DATi1 = base + 8'd1;
        DATi2 = base + 8'd2;
        DATi3 = base + 8'd3;
        DATi4 = base + 8'd4;
        DATi5 = base + 8'd5;
        DATi6 = base + 8'd6;
        DATi7 = base + 8'd7;
        ACKo  = ackO;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eStb, input logic [7:0] eDat,
                               input logic datCare, input logic eLast, input logic eAck);
        vectors++;
        assert (STBo === eStb && (!datCare || DATo === eDat) && LASTo === eLast && ACKi === eAck)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: got STBo=%b DATo=%h LASTo=%b ACKi=%b, want STBo=%b DATo=%h(care=%b) LASTo=%b ACKi=%b",
                   tag, STBo, DATo, LASTo, ACKi, eStb, eDat, datCare, eLast, eAck);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Streams a full block with STBi held high; row r lanes are base+8r .. base+8r+7.
    task automatic runBlock(input logic [7:0] base);
        int presRow;
        applyStimulus(1'b0, 1'b1, base, 1'b1);
        checkOutput("blk_load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        presRow = 1;
        for (int b = 0; b < 64; b++) begin
            if (presRow < 8) applyStimulus(1'b0, 1'b1, 8'(base + 8 * presRow), 1'b1);
            else             applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("blk_byte%0d", b), 1'b1, 8'(base + b), 1'b1,
                        (b == 63), ((b % 8 == 7) && (presRow < 8)));
            tick();
            if ((b % 8 == 7) && (presRow < 8)) presRow++;
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("blk_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] row_serializer directed test start");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rst_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Single row, STBi for one cycle; lanes are changed afterwards to prove they are not resampled.
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b1);
        checkOutput("rst_acki", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        for (int l = 0; l < 8; l++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA, 1'b1);
            checkOutput($sformatf("row_lane%0d", l), 1'b1, 8'(8'h10 + l), 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("row_done", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset, then ACKo high while empty must not move anything.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("spur_ack%0d", i), 1'b0, 8'h00, (i == 0), 1'b0, 1'b0);
            tick();
        end

        runBlock(8'h00);

        // Backpressure at lane 3, with a pending row that must wait for lane 7.
        applyStimulus(1'b0, 1'b1, 8'h20, 1'b1);
        checkOutput("bp_load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int l = 0; l < 3; l++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA, 1'b1);
            checkOutput($sformatf("bp_lane%0d", l), 1'b1, 8'(8'h20 + l), 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h30, 1'b0);
            checkOutput($sformatf("bp_stall%0d", i), 1'b1, 8'h23, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int l = 3; l < 7; l++) begin
            applyStimulus(1'b0, 1'b1, 8'h30, 1'b1);
            checkOutput($sformatf("bp_lane%0d", l), 1'b1, 8'(8'h20 + l), 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 8'h30, 1'b0);
        checkOutput("bp_lane7_noack", 1'b1, 8'h27, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h30, 1'b1);
        checkOutput("bp_lane7_reload", 1'b1, 8'h27, 1'b1, 1'b0, 1'b1);
        tick();
        for (int l = 0; l < 8; l++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA, 1'b1);
            checkOutput($sformatf("b2b_lane%0d", l), 1'b1, 8'(8'h30 + l), 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Row counter is now 2; reset at lane 4 of this row.
        applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
        checkOutput("mid_load", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int l = 0; l < 4; l++) begin
            applyStimulus(1'b0, 1'b0, 8'hAA, 1'b1);
            checkOutput($sformatf("mid_lane%0d", l), 1'b1, 8'(8'h40 + l), 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 8'h50, 1'b1);
        checkOutput("mid_lane4", 1'b1, 8'h44, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("mid_rst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        runBlock(8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
